// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded descriptors into THCO-MIPS16e words with a bound address, behind a 2-entry FIFO.
// Define ENC_RANGE_CHECK_EN to drop (and flag on err_range) descriptors whose immediate does not fit.
module instr_encoder #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op_type,
    input  logic [2:0]        rx,
    input  logic [2:0]        ry,
    input  logic [2:0]        rz,
    input  logic [15:0]       imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              err_range
);

    function automatic logic [15:0] encode(input logic [5:0] op, input logic [2:0] x,
                                           input logic [2:0] y, input logic [2:0] z,
                                           input logic [15:0] im);
        logic [15:0] w;
        w = 16'h0000;
        case (op)
            6'd0:    w = 16'b00001_00000000000;
            6'd1:    w = {5'b01001, x, im[7:0]};
            6'd2:    w = {5'b01000, x, y, 1'b0, im[3:0]};
            6'd3:    w = {5'b01100, 3'b011, im[7:0]};
            6'd4:    w = {5'b11100, x, y, z, 2'b01};
            6'd5:    w = {5'b11100, x, y, z, 2'b11};
            6'd6:    w = {5'b11101, x, y, 5'b01100};
            6'd7:    w = {5'b11101, x, y, 5'b01101};
            6'd8:    w = {5'b11101, x, y, 5'b01010};
            6'd9:    w = {5'b11101, x, 8'h00};
            6'd10:   w = {5'b00010, im[10:0]};
            6'd11:   w = {5'b00100, x, im[7:0]};
            6'd12:   w = {5'b00101, x, im[7:0]};
            6'd13:   w = {5'b01100, 3'b000, im[7:0]};
            6'd14:   w = {5'b01101, x, im[7:0]};
            6'd15:   w = {5'b10011, x, y, im[4:0]};
            6'd16:   w = {5'b11011, x, y, im[4:0]};
            6'd17:   w = {5'b00110, x, y, im[2:0], 2'b00};
            6'd18:   w = {5'b00110, x, y, im[2:0], 2'b11};
            6'd19:   w = {5'b11110, x, 8'h00};
            6'd20:   w = {5'b11110, x, 8'h01};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

`ifdef ENC_RANGE_CHECK_EN
    function automatic logic range_ok(input logic [5:0] op, input logic signed [15:0] im);
        logic ok;
        ok = 1'b1;
        case (op)
            6'd1, 6'd3, 6'd11, 6'd12, 6'd13: ok = (im >= -16'sd128) && (im <= 16'sd127);
            6'd14:        ok = (im[15:8] == 8'h00);
            6'd2:         ok = (im >= -16'sd8) && (im <= 16'sd7);
            6'd15, 6'd16: ok = (im >= -16'sd16) && (im <= 16'sd15);
            6'd10:        ok = (im >= -16'sd1024) && (im <= 16'sd1023);
            6'd17, 6'd18: ok = (im >= 16'sd1) && (im <= 16'sd8);
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    logic [15:0]       r_head_word, r_tail_word;
    logic [ADDR_W-1:0] r_head_addr, r_tail_addr;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_ctr;
    logic              r_err_illegal;
    logic              w_accept, w_pop, w_legal, w_in_range, w_push;
    logic [15:0]       w_word;
    logic signed [15:0] w_imm_s;

    assign w_imm_s  = imm;
    assign in_ready = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;
    assign w_legal  = (op_type <= 6'd20);
    assign w_word   = encode(op_type, rx, ry, rz, w_imm_s);
    assign w_push   = w_accept & w_legal & w_in_range;

`ifdef ENC_RANGE_CHECK_EN
    logic r_err_range;
    assign w_in_range = range_ok(op_type, w_imm_s);
    assign err_range  = r_err_range & ~rst;

    always_ff @(posedge clk) begin
        if (rst) r_err_range <= 1'b0;
        else     r_err_range <= w_accept & w_legal & ~w_in_range;
    end
`else
    logic w_unused_imm;
    assign w_unused_imm = ^w_imm_s[15:11];
    assign w_in_range   = 1'b1;
    assign err_range    = 1'b0;
`endif

    // Gated by rst so a pulse registered just before reset never shows during it.
    assign err_illegal = r_err_illegal & ~rst;
    assign out_word    = r_head_word;
    assign out_addr    = r_head_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_word   <= 16'h0000;
            r_head_addr   <= '0;
            r_tail_word   <= 16'h0000;
            r_tail_addr   <= '0;
            r_count       <= 2'd0;
            r_ctr         <= BASE_ADDR;
            r_err_illegal <= 1'b0;
        end else begin
            r_err_illegal <= w_accept & ~w_legal;
            if (addr_load)   r_ctr <= addr_value;
            else if (w_push) r_ctr <= r_ctr + 1'b1;
            // Push together with pop only happens at count 1, so the new word becomes the head.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_word <= w_word;
                        r_head_addr <= r_ctr;
                    end else begin
                        r_tail_word <= w_word;
                        r_tail_addr <= r_ctr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head_word <= r_tail_word;
                    r_head_addr <= r_tail_addr;
                    r_count     <= r_count - 2'd1;
                end
                2'b11: begin
                    r_head_word <= w_word;
                    r_head_addr <= r_ctr;
                end
                default: ;
            endcase
        end
    end

endmodule
